// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, execute, memory and
// write-back, decoding datapath enables/selects from state and instruction class.
module mc_ctrl #(
  parameter bit ILLEGAL_HALT = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             ir_we,
  output logic             rf_we,
  output logic [1:0]       rf_wa_sel,
  output logic [1:0]       rf_wd_sel,
  output logic [1:0]       alu_op,
  output logic             alu_bsel,
  output logic [1:0]       ext_op,
  output logic             dm_we,
  output logic             instr_done,
  output logic             halted,
  output logic [CNT_W-1:0] icount
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_R_ADD, C_R_SUB, C_ORI, C_LUI, C_LW, C_SW, C_BEQ} cls_t;
  typedef enum logic [2:0] {K_NOP, K_J, K_JAL, K_JR, K_EXEC, K_ILL} kind_t;

  state_t state, state_nx;
  cls_t   cls, dec_cls;
  kind_t  dec_kind;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dec_kind = K_ILL;
    dec_cls  = C_R_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_NOP:  dec_kind = K_NOP;
          FN_JR:   dec_kind = K_JR;
          FN_ADDU: begin dec_kind = K_EXEC; dec_cls = C_R_ADD; end
          FN_SUBU: begin dec_kind = K_EXEC; dec_cls = C_R_SUB; end
          default: dec_kind = K_ILL;
        endcase
      end
      OP_J:    dec_kind = K_J;
      OP_JAL:  dec_kind = K_JAL;
      OP_BEQ:  begin dec_kind = K_EXEC; dec_cls = C_BEQ; end
      OP_ORI:  begin dec_kind = K_EXEC; dec_cls = C_ORI; end
      OP_LUI:  begin dec_kind = K_EXEC; dec_cls = C_LUI; end
      OP_LW:   begin dec_kind = K_EXEC; dec_cls = C_LW;  end
      OP_SW:   begin dec_kind = K_EXEC; dec_cls = C_SW;  end
      default: dec_kind = K_ILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset here is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      cls    <= C_R_ADD;
      icount <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE && dec_kind == K_EXEC) cls <= dec_cls;
      if (instr_done) icount <= icount + CNT_W'(1);
    end
  end

  // Enables are only produced out of reset, so no write pulses in a reset cycle.
  always_comb begin
    state_nx   = state;
    pc_we      = 1'b0;
    npc_sel    = 2'd0;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    rf_wa_sel  = 2'd0;
    rf_wd_sel  = 2'd0;
    alu_op     = 2'd0;
    alu_bsel   = 1'b0;
    ext_op     = 2'd0;
    dm_we      = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          ir_we    = 1'b1;
          pc_we    = 1'b1;
          state_nx = S_DECODE;
        end
        S_DECODE: begin
          state_nx = S_FETCH;
          case (dec_kind)
            K_NOP: instr_done = 1'b1;
            K_J: begin
              pc_we = 1'b1; npc_sel = 2'd2; instr_done = 1'b1;
            end
            K_JAL: begin
              pc_we = 1'b1; npc_sel = 2'd2; rf_we = 1'b1;
              rf_wa_sel = 2'd2; rf_wd_sel = 2'd2; instr_done = 1'b1;
            end
            K_JR: begin
              pc_we = 1'b1; npc_sel = 2'd3; instr_done = 1'b1;
            end
            K_EXEC: state_nx = S_EXEC;
            default: begin
              if (ILLEGAL_HALT) state_nx = S_HALT;
              else              instr_done = 1'b1;
            end
          endcase
        end
        S_EXEC: begin
          case (cls)
            C_R_ADD: begin alu_op = 2'd0; state_nx = S_WB; end
            C_R_SUB: begin alu_op = 2'd1; state_nx = S_WB; end
            C_ORI: begin
              alu_bsel = 1'b1; ext_op = 2'd0; alu_op = 2'd2; state_nx = S_WB;
            end
            C_LUI: begin
              alu_bsel = 1'b1; ext_op = 2'd2; alu_op = 2'd3; state_nx = S_WB;
            end
            C_LW, C_SW: begin
              alu_bsel = 1'b1; ext_op = 2'd1; alu_op = 2'd0; state_nx = S_MEM;
            end
            default: begin
              alu_op = 2'd1; ext_op = 2'd1; pc_we = zero; npc_sel = 2'd1;
              instr_done = 1'b1; state_nx = S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (cls == C_SW) begin
            dm_we = 1'b1; instr_done = 1'b1; state_nx = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end
        S_WB: begin
          rf_we      = 1'b1;
          instr_done = 1'b1;
          state_nx   = S_FETCH;
          case (cls)
            C_R_ADD, C_R_SUB: rf_wa_sel = 2'd1;
            C_LW:             rf_wd_sel = 2'd1;
            default:          rf_wa_sel = 2'd0;
          endcase
        end
        default: halted = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks every instruction class cycle by cycle and
// checks outputs, icount, reset behaviour, HALT and counter wrap.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset, zero, reset4;
  logic [5:0] opcode, funct, opcode4, funct4;

  logic       pc_we, ir_we, rf_we, alu_bsel, dm_we, instr_done, halted;
  logic [1:0] npc_sel, rf_wa_sel, rf_wd_sel, alu_op, ext_op;
  logic [31:0] icount;

  logic       pc_we4, ir_we4, rf_we4, alu_bsel4, dm_we4, instr_done4, halted4;
  logic [1:0] npc_sel4, rf_wa_sel4, rf_wd_sel4, alu_op4, ext_op4;
  logic [3:0] icount4;

  logic [16:0] outs, outs4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we), .rf_we(rf_we),
    .rf_wa_sel(rf_wa_sel), .rf_wd_sel(rf_wd_sel), .alu_op(alu_op),
    .alu_bsel(alu_bsel), .ext_op(ext_op), .dm_we(dm_we),
    .instr_done(instr_done), .halted(halted), .icount(icount)
  );

  mc_ctrl #(.ILLEGAL_HALT(1'b0), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset4), .opcode(opcode4), .funct(funct4), .zero(1'b0),
    .pc_we(pc_we4), .npc_sel(npc_sel4), .ir_we(ir_we4), .rf_we(rf_we4),
    .rf_wa_sel(rf_wa_sel4), .rf_wd_sel(rf_wd_sel4), .alu_op(alu_op4),
    .alu_bsel(alu_bsel4), .ext_op(ext_op4), .dm_we(dm_we4),
    .instr_done(instr_done4), .halted(halted4), .icount(icount4)
  );

  assign outs  = {pc_we, npc_sel, ir_we, rf_we, rf_wa_sel, rf_wd_sel, alu_op,
                  alu_bsel, ext_op, dm_we, instr_done, halted};
  assign outs4 = {pc_we4, npc_sel4, ir_we4, rf_we4, rf_wa_sel4, rf_wd_sel4, alu_op4,
                  alu_bsel4, ext_op4, dm_we4, instr_done4, halted4};

  // Field order: pc_we npc ir_we rf_we wa wd alu_op bsel ext dm_we done halted
  function automatic logic [16:0] mk(input logic pc, input logic [1:0] npc,
                                     input logic ir, input logic rf,
                                     input logic [1:0] wa, input logic [1:0] wd,
                                     input logic [1:0] op, input logic bs,
                                     input logic [1:0] ext, input logic dm,
                                     input logic done, input logic hlt);
    return {pc, npc, ir, rf, wa, wd, op, bs, ext, dm, done, hlt};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [16:0] e);
    #1;
    check(tag, {15'd0, outs}, {15'd0, e});
    tick();
  endtask

  task automatic fetch(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] exp_cnt);
    opcode = op;
    funct  = fn;
    check({tag, "_icnt"}, icount, exp_cnt);
    cyc({tag, "_fetch"}, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  logic [16:0] z_v, wb_rd, wb_rt, ldst_ex;

  initial begin
    z_v     = '0;
    wb_rd   = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    wb_rt   = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    ldst_ex = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    reset = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
    reset4 = 1'b1; opcode4 = '0; funct4 = '0;

    tick();
    check("rst_outs", {15'd0, outs}, 32'd0);
    check("rst_icnt", icount, 32'd0);
    tick();
    reset = 1'b0;

    fetch("addu", 6'h00, 6'h21, 0);
    cyc("addu_dec", z_v);
    cyc("addu_exec", z_v);
    cyc("addu_wb", wb_rd);

    fetch("subu", 6'h00, 6'h23, 1);
    cyc("subu_dec", z_v);
    cyc("subu_exec", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    cyc("subu_wb", wb_rd);

    fetch("ori", 6'h0D, 6'h00, 2);
    cyc("ori_dec", z_v);
    cyc("ori_exec", mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
    cyc("ori_wb", wb_rt);

    fetch("lui", 6'h0F, 6'h00, 3);
    cyc("lui_dec", z_v);
    cyc("lui_exec", mk(0, 0, 0, 0, 0, 0, 3, 1, 2, 0, 0, 0));
    cyc("lui_wb", wb_rt);

    fetch("lw", 6'h23, 6'h00, 4);
    cyc("lw_dec", z_v);
    cyc("lw_exec", ldst_ex);
    cyc("lw_mem", z_v);
    cyc("lw_wb", mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));

    fetch("sw", 6'h2B, 6'h00, 5);
    cyc("sw_dec", z_v);
    cyc("sw_exec", ldst_ex);
    cyc("sw_mem", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));

    zero = 1'b1;
    fetch("beq_t", 6'h04, 6'h00, 6);
    cyc("beq_t_dec", z_v);
    cyc("beq_t_exec", mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));

    zero = 1'b0;
    fetch("beq_n", 6'h04, 6'h00, 7);
    cyc("beq_n_dec", z_v);
    cyc("beq_n_exec", mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));

    fetch("jal", 6'h03, 6'h00, 8);
    cyc("jal_dec", mk(1, 2, 0, 1, 2, 2, 0, 0, 0, 0, 1, 0));

    fetch("j", 6'h02, 6'h00, 9);
    cyc("j_dec", mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    fetch("jr", 6'h00, 6'h08, 10);
    cyc("jr_dec", mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    fetch("nop", 6'h00, 6'h00, 11);
    cyc("nop_dec", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Reset landing in the MEM cycle of a load and of a store.
    fetch("lw_rst", 6'h23, 6'h00, 12);
    cyc("lw_rst_dec", z_v);
    cyc("lw_rst_exec", ldst_ex);
    reset = 1'b1;
    cyc("lw_rst_mem", z_v);
    reset = 1'b0;

    fetch("sw_rst", 6'h2B, 6'h00, 0);
    cyc("sw_rst_dec", z_v);
    cyc("sw_rst_exec", ldst_ex);
    reset = 1'b1;
    cyc("sw_rst_mem", z_v);
    reset = 1'b0;

    fetch("ill", 6'h3F, 6'h00, 0);
    cyc("ill_dec", z_v);
    for (int i = 0; i < 10; i++) cyc($sformatf("halt_%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    check("halt_icnt", icount, 32'd0);
    reset = 1'b1;
    cyc("halt_rst", z_v);
    reset = 1'b0;
    fetch("post_halt", 6'h00, 6'h00, 0);
    cyc("post_halt_dec", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    check("post_halt_icnt", icount, 32'd1);

    // Narrow counter with illegal-as-nop: 15 retires, then wrap on the 16th.
    reset4 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      tick();
    end
    check("wrap_15", {28'd0, icount4}, 32'd15);
    tick();
    tick();
    check("wrap_0", {28'd0, icount4}, 32'd0);
    opcode4 = 6'h3F;
    tick();
    #1;
    check("ill_nop_dec", {15'd0, outs4}, {15'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
    tick();
    check("ill_nop_icnt", {28'd0, icount4}, 32'd1);
    check("ill_nop_fetch", {15'd0, outs4}, {15'd0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
